// File: rtl/bali_pkg.sv
// Shared definitions for the BALI execute unit: ALU op encoding (also driven by the
// bytecode decoder), default datapath width and divider state encoding.
package bali_pkg;

  localparam int unsigned BALI_WIDTH = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'h0,
    ALU_SUB  = 4'h1,
    ALU_MUL  = 4'h2,
    ALU_DIV  = 4'h3,
    ALU_REM  = 4'h4,
    ALU_NEG  = 4'h5,
    ALU_SHL  = 4'h6,
    ALU_SHR  = 4'h7,
    ALU_USHR = 4'h8,
    ALU_AND  = 4'h9,
    ALU_OR   = 4'hA,
    ALU_XOR  = 4'hB,
    ALU_CMP  = 4'hC,
    ALU_PASS = 4'hD
  } alu_op_t;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_RUN,
    DIV_DONE
  } div_state_t;

endpackage

// File: rtl/bali_divider.sv
// Unsigned restoring shift-subtract divider: WIDTH iterations in RUN, results held in DONE.
module bali_divider
  import bali_pkg::*;
#(
  parameter int unsigned WIDTH = BALI_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  div_state_t       state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DIV_IDLE;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      DIV_IDLE: if (start) state_d = DIV_RUN;
      DIV_RUN:  if (count_q == '0) state_d = DIV_DONE;
      DIV_DONE: state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase
  end

  // The partial remainder stays below the divisor, so bit WIDTH of diff is purely the borrow.
  always_comb begin
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    count_d = count_q;
    trial   = {rem_q, quo_q[WIDTH-1]};
    diff    = trial - {1'b0, dvs_q};
    if (state_q == DIV_IDLE && start) begin
      rem_d   = '0;
      quo_d   = dividend;
      dvs_d   = divisor;
      count_d = CW'(WIDTH - 1);
    end else if (state_q == DIV_RUN) begin
      count_d = count_q - CW'(1);
      if (!diff[WIDTH]) begin
        rem_d = diff[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_d = trial[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_comb begin
    busy      = (state_q != DIV_IDLE);
    done      = (state_q == DIV_DONE);
    quotient  = quo_q;
    remainder = rem_q;
  end

endmodule

// File: rtl/bali_alu.sv
// BALI 32-bit execute unit: single-cycle ALU ops plus iterative signed DIV/REM with
// ready/valid handshake; sign handling and divide special cases live here.
module bali_alu
  import bali_pkg::*;
#(
  parameter int unsigned WIDTH = BALI_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             ready,
  input  logic [3:0]       op_select,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             out_valid,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             div_zero
);

  localparam int unsigned SHW = $clog2(WIDTH);

  alu_op_t            op;
  logic               accept, is_div_op, b_zero;
  logic [SHW-1:0]     shamt;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   alu_lo, alu_hi;
  logic [WIDTH-1:0]   mag_a, mag_b, quo_fix, rem_fix;
  logic               div_start, div_busy, div_done;
  logic [WIDTH-1:0]   div_quo, div_rem;

  logic             ready_q, ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             div_zero_q, div_zero_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic             is_rem_q, is_rem_d;

  assign op        = alu_op_t'(op_select);
  assign shamt     = operand_b[SHW-1:0];
  assign accept    = in_valid & ready_q & ~div_busy;
  assign is_div_op = (op == ALU_DIV) || (op == ALU_REM);
  assign b_zero    = (operand_b == '0);
  assign mag_a     = operand_a[WIDTH-1] ? ('0 - operand_a) : operand_a;
  assign mag_b     = operand_b[WIDTH-1] ? ('0 - operand_b) : operand_b;
  assign div_start = accept & is_div_op & ~b_zero;
  assign quo_fix   = q_neg_q ? ('0 - div_quo) : div_quo;
  assign rem_fix   = r_neg_q ? ('0 - div_rem) : div_rem;

  bali_divider #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .dividend  (mag_a),
    .divisor   (mag_b),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  // Sign-extending both operands to 2*WIDTH makes the unsigned product equal the signed one.
  always_comb begin
    prod   = {{WIDTH{operand_a[WIDTH-1]}}, operand_a} * {{WIDTH{operand_b[WIDTH-1]}}, operand_b};
    alu_lo = '0;
    alu_hi = '0;
    case (op)
      ALU_ADD:  alu_lo = operand_a + operand_b;
      ALU_SUB:  alu_lo = operand_a - operand_b;
      ALU_MUL: begin
        alu_lo = prod[WIDTH-1:0];
        alu_hi = prod[2*WIDTH-1:WIDTH];
      end
      ALU_DIV, ALU_REM: alu_lo = '0;
      ALU_NEG:  alu_lo = '0 - operand_a;
      ALU_SHL:  alu_lo = operand_a << shamt;
      ALU_SHR:  alu_lo = $signed(operand_a) >>> shamt;
      ALU_USHR: alu_lo = operand_a >> shamt;
      ALU_AND:  alu_lo = operand_a & operand_b;
      ALU_OR:   alu_lo = operand_a | operand_b;
      ALU_XOR:  alu_lo = operand_a ^ operand_b;
      ALU_CMP: begin
        if ($signed(operand_a) < $signed(operand_b)) alu_lo = '1;
        else if (operand_a != operand_b)             alu_lo = WIDTH'(1);
      end
      default:  alu_lo = operand_a;
    endcase
  end

  always_comb begin
    ready_d     = ready_q;
    out_valid_d = 1'b0;
    lo_d        = lo_q;
    hi_d        = hi_q;
    div_zero_d  = 1'b0;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    is_rem_d    = is_rem_q;
    if (div_done) begin
      out_valid_d = 1'b1;
      ready_d     = 1'b1;
      lo_d        = is_rem_q ? rem_fix : quo_fix;
      hi_d        = is_rem_q ? quo_fix : rem_fix;
    end else if (accept) begin
      if (is_div_op && b_zero) begin
        out_valid_d = 1'b1;
        div_zero_d  = 1'b1;
        lo_d        = '0;
        hi_d        = operand_a;
      end else if (is_div_op) begin
        ready_d  = 1'b0;
        q_neg_d  = operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
        r_neg_d  = operand_a[WIDTH-1];
        is_rem_d = (op == ALU_REM);
      end else begin
        out_valid_d = 1'b1;
        lo_d        = alu_lo;
        hi_d        = alu_hi;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_q     <= 1'b1;
      out_valid_q <= 1'b0;
      lo_q        <= '0;
      hi_q        <= '0;
      div_zero_q  <= 1'b0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      is_rem_q    <= 1'b0;
    end else begin
      ready_q     <= ready_d;
      out_valid_q <= out_valid_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      div_zero_q  <= div_zero_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      is_rem_q    <= is_rem_d;
    end
  end

  assign ready     = ready_q;
  assign out_valid = out_valid_q;
  assign result_lo = lo_q;
  assign result_hi = hi_q;
  assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_bali_alu.sv
// Scoreboard bench for bali_alu: the driver queues expected responses, a negedge monitor
// pops and compares them (values and arrival cycle) whenever out_valid is seen.
module tb_bali_alu;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         ready;
  logic [3:0]   op_select;
  logic [W-1:0] operand_a, operand_b;
  logic         out_valid;
  logic [W-1:0] result_lo, result_hi;
  logic         div_zero;

  int unsigned cyc    = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         dz;
    int unsigned  lat;
    int unsigned  when;
  } exp_t;

  exp_t sbq[$];

  bali_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .ready     (ready),
    .op_select (op_select),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .out_valid (out_valid),
    .result_lo (result_lo),
    .result_hi (result_hi),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Reference model: plain signed integer arithmetic following the ISA rules.
  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   e;
    int     sa, sb, q, r;
    longint p;
    sa = a;
    sb = b;
    e.op = op; e.lo = '0; e.hi = '0; e.dz = 1'b0; e.lat = 0; e.when = 0;
    case (op)
      4'h0: e.lo = a + b;
      4'h1: e.lo = a - b;
      4'h2: begin p = longint'(sa) * longint'(sb); e.lo = p[31:0]; e.hi = p[63:32]; end
      4'h3, 4'h4: begin
        if (sb == 0) begin
          e.dz = 1'b1; e.lo = '0; e.hi = a;
        end else begin
          e.lat = 33;
          if (sa == 32'sh8000_0000 && sb == -1) begin q = sa; r = 0; end
          else begin q = sa / sb; r = sa % sb; end
          if (op == 4'h3) begin e.lo = q; e.hi = r; end
          else            begin e.lo = r; e.hi = q; end
        end
      end
      4'h5: e.lo = -sa;
      4'h6: e.lo = a << b[4:0];
      4'h7: e.lo = sa >>> b[4:0];
      4'h8: e.lo = a >> b[4:0];
      4'h9: e.lo = a & b;
      4'hA: e.lo = a | b;
      4'hB: e.lo = a ^ b;
      4'hC: e.lo = (sa < sb) ? 32'hFFFF_FFFF : ((sa == sb) ? 32'h0 : 32'h1);
      default: e.lo = a;
    endcase
    return e;
  endfunction

  // Waits for ready (scrambling inputs meanwhile, which the DUT must ignore), then issues.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input exp_t e);
    int unsigned guard;
    guard = 0;
    @(negedge clk);
    while (!ready && guard < 100) begin
      in_valid  = 1'($urandom_range(0, 1));
      op_select = 4'($urandom);
      operand_a = $urandom;
      operand_b = $urandom;
      @(negedge clk);
      guard++;
    end
    if (!ready) begin
      checks++; errors++;
      $display("FAIL ready_timeout: ready still %b after %0d cycles, required 1", ready, guard);
      in_valid = 1'b0;
      return;
    end
    in_valid  = 1'b1;
    op_select = op;
    operand_a = a;
    operand_b = b;
    e.when = cyc + 1 + e.lat;
    sbq.push_back(e);
  endtask

  task automatic t(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                   input logic [W-1:0] lo, input logic [W-1:0] hi, input logic dz);
    exp_t e;
    e.op = op; e.lo = lo; e.hi = hi; e.dz = dz; e.when = 0;
    e.lat = ((op == 4'h3 || op == 4'h4) && b != 0) ? 33 : 0;
    issue(op, a, b, e);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  function automatic logic [W-1:0] rnd_val();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return W'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (out_valid) begin
      if (sbq.size() == 0) begin
        checks++; errors++;
        $display("FAIL stray_out_valid: got out_valid=1 lo=%h, required no output", result_lo);
      end else begin
        e = sbq.pop_front();
        chk($sformatf("latency_op%h", e.op), 64'(cyc), 64'(e.when));
        chk($sformatf("lo_op%h", e.op), 64'(result_lo), 64'(e.lo));
        chk($sformatf("hi_op%h", e.op), 64'(result_hi), 64'(e.hi));
        chk($sformatf("div_zero_op%h", e.op), 64'(div_zero), 64'(e.dz));
      end
    end
  end

  initial begin
    logic [3:0]   op;
    logic [W-1:0] a, b;
    int unsigned  guard;
    rst = 1'b1; in_valid = 1'b0; op_select = '0; operand_a = '0; operand_b = '0;
    repeat (3) @(negedge clk);
    chk("reset_ready", 64'(ready), 64'd1);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_lo", 64'(result_lo), 64'd0);
    chk("reset_hi", 64'(result_hi), 64'd0);
    chk("reset_div_zero", 64'(div_zero), 64'd0);
    rst = 1'b0;

    t(4'h0, 32'd7, 32'd5, 32'd12, 32'd0, 1'b0);
    t(4'h1, 32'd5, 32'd7, 32'hFFFF_FFFE, 32'd0, 1'b0);
    t(4'h0, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 32'd0, 1'b0);
    t(4'h2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b0);
    t(4'h2, 32'h0001_0000, 32'h0001_0000, 32'd0, 32'd1, 1'b0);
    t(4'h6, 32'd1, 32'd33, 32'd2, 32'd0, 1'b0);
    t(4'h7, 32'h8000_0000, 32'd4, 32'hF800_0000, 32'd0, 1'b0);
    t(4'h8, 32'h8000_0000, 32'd4, 32'h0800_0000, 32'd0, 1'b0);
    t(4'hC, 32'd3, 32'hFFFF_FFFD, 32'd1, 32'd0, 1'b0);
    t(4'hC, 32'hFFFF_FFFD, 32'd3, 32'hFFFF_FFFF, 32'd0, 1'b0);
    t(4'hC, 32'd4, 32'd4, 32'd0, 32'd0, 1'b0);
    t(4'h5, 32'd5, 32'd9, 32'hFFFF_FFFB, 32'd0, 1'b0);
    t(4'h9, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 32'd0, 1'b0);
    t(4'hA, 32'hF000_0001, 32'h0000_0F00, 32'hF000_0F01, 32'd0, 1'b0);
    t(4'hB, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 32'd0, 1'b0);
    t(4'hE, 32'hDEAD_BEEF, 32'd1, 32'hDEAD_BEEF, 32'd0, 1'b0);
    t(4'h3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    t(4'h4, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0);
    t(4'h3, 32'd5, 32'd0, 32'd0, 32'd5, 1'b1);
    t(4'h4, 32'd9, 32'd0, 32'd0, 32'd9, 1'b1);
    t(4'h3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
    t(4'h4, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
    t(4'h0, 32'd2, 32'd3, 32'd5, 32'd0, 1'b0);
    idle();

    // Abort a divide partway through; its queued result must never appear.
    t(4'h3, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    idle();
    repeat (8) @(negedge clk);
    rst = 1'b1;
    sbq.delete();
    #1;
    chk("abort_ready", 64'(ready), 64'd1);
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_lo", 64'(result_lo), 64'd0);
    chk("abort_hi", 64'(result_hi), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("post_abort_ready", 64'(ready), 64'd1);
    t(4'h0, 32'd1, 32'd1, 32'd2, 32'd0, 1'b0);

    for (int i = 0; i < 200; i++) begin
      op = ($urandom_range(0, 3) == 0) ? 4'(3 + $urandom_range(0, 1)) : 4'($urandom_range(0, 15));
      a  = rnd_val();
      b  = rnd_val();
      issue(op, a, b, model(op, a, b));
      if ($urandom_range(0, 4) == 0) idle();
    end
    idle();

    guard = 0;
    while (sbq.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (sbq.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain: %0d responses outstanding, required 0", sbq.size());
    end
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
